// File: rtl/lfsr_burst_ctrl.sv
// Control unit for the LFSR random engine: seed load, warm-up, then free-run or
// fixed-length burst output under a val/rdy handshake.
module lfsr_burst_ctrl #(
    parameter int CNT_W  = 16,
    parameter int WARMUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic [CNT_W-1:0] burst_len,
    input  logic             out_rdy,
    output logic             out_val,
    output logic             lfsr_load,
    output logic             lfsr_en,
    output logic             active,
    output logic             done,
    output logic [CNT_W-1:0] count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WARM,
        S_RUN
    } state_e;

    // With WARMUP=0 the WARM state is unreachable, so the wrapped value is never used.
    localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'(WARMUP - 1);
    localparam bit               HAS_WARM  = (WARMUP > 0);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] warm_q,  warm_d;
    logic             mode_q,  mode_d;
    logic             done_q,  done_d;

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            count_q <= '0;
            warm_q  <= '0;
            mode_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            warm_q  <= warm_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
        end
    end

    // NOTE: every always_comb target gets a default first so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        warm_d    = warm_q;
        mode_d    = mode_q;
        done_d    = 1'b0;
        out_val   = 1'b0;
        lfsr_load = 1'b0;
        lfsr_en   = 1'b0;
        active    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (!mode || (burst_len != '0)) begin
                        mode_d  = mode;
                        count_d = burst_len;
                        state_d = S_LOAD;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end

            S_LOAD: begin
                lfsr_load = 1'b1;
                active    = 1'b1;
                warm_d    = '0;
                if (stop) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = HAS_WARM ? S_WARM : S_RUN;
                end
            end

            S_WARM: begin
                lfsr_en = 1'b1;
                active  = 1'b1;
                warm_d  = warm_q + 1'b1;
                if (stop) begin
                    state_d = S_IDLE;
                end else if (warm_q == WARM_LAST) begin
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                out_val = 1'b1;
                active  = 1'b1;
                lfsr_en = out_rdy;
                // A handshake in the stop cycle still retires its word.
                if (out_rdy && mode_q && (count_q != '0)) begin
                    count_d = count_q - 1'b1;
                    if (count_q == CNT_W'(1)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
                if (stop) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign done  = done_q;
    assign count = count_q;

endmodule

// File: tb/tb_lfsr_burst_ctrl.sv
// Directed bench for lfsr_burst_ctrl: burst timing, back-pressure, free-run/stop,
// zero-length burst, ignored restart, stop/last-word overlap, WARMUP=0, mid-run reset.
module tb_lfsr_burst_ctrl;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst, start, stop, mode, out_rdy;
    logic [CNT_W-1:0] burst_len;
    logic             out_val, lfsr_load, lfsr_en, active, done;
    logic [CNT_W-1:0] count;

    // Second instance with no warm-up; it has its own start and stop.
    logic             start0, stop0;
    logic             out_val0, lfsr_load0, lfsr_en0, active0, done0;
    logic [CNT_W-1:0] count0;

    int total = 0;
    int bad   = 0;
    int hs;

    always #5 clk = ~clk;

    lfsr_burst_ctrl #(.CNT_W(CNT_W), .WARMUP(4)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
        .burst_len(burst_len), .out_rdy(out_rdy), .out_val(out_val),
        .lfsr_load(lfsr_load), .lfsr_en(lfsr_en), .active(active),
        .done(done), .count(count)
    );

    lfsr_burst_ctrl #(.CNT_W(CNT_W), .WARMUP(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .stop(stop0), .mode(mode),
        .burst_len(burst_len), .out_rdy(out_rdy), .out_val(out_val0),
        .lfsr_load(lfsr_load0), .lfsr_en(lfsr_en0), .active(active0),
        .done(done0), .count(count0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Expected vector order: {out_val, lfsr_load, lfsr_en, active, done}.
    task automatic cyc(input string tag, input logic [4:0] ev, input logic [CNT_W-1:0] ec,
                       input bit use_dut0 = 1'b0);
        #1;
        if (use_dut0) begin
            check({tag, "_outs"}, {27'd0, out_val0, lfsr_load0, lfsr_en0, active0, done0}, {27'd0, ev});
            check({tag, "_cnt"}, {24'd0, count0}, {24'd0, ec});
        end else begin
            check({tag, "_outs"}, {27'd0, out_val, lfsr_load, lfsr_en, active, done}, {27'd0, ev});
            check({tag, "_cnt"}, {24'd0, count}, {24'd0, ec});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic       rdy_pat [6];
        logic [7:0] cnt_pat [6];
        rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        cnt_pat = '{8'd3, 8'd2, 8'd2, 8'd2, 8'd1, 8'd1};

        rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0; out_rdy = 1'b0;
        burst_len = '0; start0 = 1'b0; stop0 = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        cyc("reset", 5'b00000, 8'd0);
        cyc("reset0", 5'b00000, 8'd0, 1'b1);

        // Burst of 3, consumer always ready.
        mode = 1'b1; burst_len = 8'd3; out_rdy = 1'b1; start = 1'b1;
        cyc("b_c0", 5'b00000, 8'd0);
        start = 1'b0;
        cyc("b_load", 5'b01010, 8'd3);
        for (int i = 0; i < 4; i++) cyc($sformatf("b_warm%0d", i), 5'b00110, 8'd3);
        for (int i = 0; i < 3; i++) cyc($sformatf("b_run%0d", i), 5'b10110, CNT_W'(3 - i));
        cyc("b_done", 5'b00001, 8'd0);
        cyc("b_idle", 5'b00000, 8'd0);

        // Same burst with back-pressure in RUN.
        start = 1'b1;
        cyc("bp_c0", 5'b00000, 8'd0);
        start = 1'b0;
        cyc("bp_load", 5'b01010, 8'd3);
        for (int i = 0; i < 4; i++) cyc($sformatf("bp_warm%0d", i), 5'b00110, 8'd3);
        for (int i = 0; i < 6; i++) begin
            out_rdy = rdy_pat[i];
            cyc($sformatf("bp_run%0d", i), {1'b1, 1'b0, rdy_pat[i], 1'b1, 1'b0}, cnt_pat[i]);
        end
        out_rdy = 1'b1;
        cyc("bp_done", 5'b00001, 8'd0);

        // Free-run with stop on the 10th RUN cycle.
        mode = 1'b0; burst_len = 8'd5; start = 1'b1;
        cyc("fr_c0", 5'b00000, 8'd0);
        start = 1'b0;
        cyc("fr_load", 5'b01010, 8'd5);
        for (int i = 0; i < 4; i++) cyc($sformatf("fr_warm%0d", i), 5'b00110, 8'd5);
        hs = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 9) stop = 1'b1;
            #1;
            if (out_val && lfsr_en) hs++;
            cyc($sformatf("fr_run%0d", i), 5'b10110, 8'd5);
        end
        stop = 1'b0;
        check("fr_handshakes", hs, 10);
        cyc("fr_stopped", 5'b00000, 8'd5);

        // Zero-length burst: no LOAD, done next cycle, count untouched.
        mode = 1'b1; burst_len = 8'd0; start = 1'b1;
        cyc("z_c0", 5'b00000, 8'd5);
        start = 1'b0;
        cyc("z_done", 5'b00001, 8'd5);
        cyc("z_idle", 5'b00000, 8'd5);

        // Start re-pulsed in WARM with a different length is ignored.
        burst_len = 8'd2; start = 1'b1;
        cyc("ig_c0", 5'b00000, 8'd5);
        start = 1'b0;
        cyc("ig_load", 5'b01010, 8'd2);
        cyc("ig_warm0", 5'b00110, 8'd2);
        start = 1'b1; burst_len = 8'd7;
        cyc("ig_warm1", 5'b00110, 8'd2);
        start = 1'b0; burst_len = 8'd2;
        cyc("ig_warm2", 5'b00110, 8'd2);
        cyc("ig_warm3", 5'b00110, 8'd2);
        cyc("ig_run0", 5'b10110, 8'd2);
        cyc("ig_run1", 5'b10110, 8'd1);
        cyc("ig_done", 5'b00001, 8'd0);

        // Stop coincident with the final handshake still completes the burst.
        start = 1'b1;
        cyc("ov_c0", 5'b00000, 8'd0);
        start = 1'b0;
        cyc("ov_load", 5'b01010, 8'd2);
        for (int i = 0; i < 4; i++) cyc($sformatf("ov_warm%0d", i), 5'b00110, 8'd2);
        cyc("ov_run0", 5'b10110, 8'd2);
        stop = 1'b1;
        cyc("ov_run1", 5'b10110, 8'd1);
        stop = 1'b0;
        cyc("ov_done", 5'b00001, 8'd0);

        // Stop in WARM aborts without done.
        burst_len = 8'd3; start = 1'b1;
        cyc("sw_c0", 5'b00000, 8'd0);
        start = 1'b0;
        cyc("sw_load", 5'b01010, 8'd3);
        stop = 1'b1;
        cyc("sw_warm0", 5'b00110, 8'd3);
        stop = 1'b0;
        cyc("sw_idle0", 5'b00000, 8'd3);
        cyc("sw_idle1", 5'b00000, 8'd3);

        // WARMUP=0: out_val two cycles after start.
        burst_len = 8'd1; out_rdy = 1'b1; start0 = 1'b1;
        cyc("w0_c0", 5'b00000, 8'd0, 1'b1);
        start0 = 1'b0;
        cyc("w0_load", 5'b01010, 8'd1, 1'b1);
        cyc("w0_run", 5'b10110, 8'd1, 1'b1);
        cyc("w0_done", 5'b00001, 8'd0, 1'b1);

        // Reset held two cycles mid-RUN under back-pressure.
        burst_len = 8'd5; out_rdy = 1'b0; start = 1'b1;
        cyc("mr_c0", 5'b00000, 8'd3);
        start = 1'b0;
        cyc("mr_load", 5'b01010, 8'd5);
        for (int i = 0; i < 4; i++) cyc($sformatf("mr_warm%0d", i), 5'b00110, 8'd5);
        cyc("mr_run0", 5'b10010, 8'd5);
        cyc("mr_run1", 5'b10010, 8'd5);
        rst = 1'b1;
        cyc("mr_pre", 5'b10010, 8'd5);
        cyc("mr_rst1", 5'b00000, 8'd0);
        rst = 1'b0;
        cyc("mr_rst2", 5'b00000, 8'd0);
        cyc("mr_post", 5'b00000, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lfsr_burst_ctrl.md
Name: lfsr_burst_ctrl

Overview:
- Next-generation control unit for the LFSR random engine. Extends start/stop free-running control with:
  - a seed-load phase;
  - a parametrised warm-up phase;
  - a burst mode that emits exactly N words;
  - a val/rdy output handshake, so the LFSR advances only when a consumer accepts a word.
- Drives the engine datapath (load and advance enables) and exposes status to the I/O interface.

Parameters:
- CNT_W, 16: width of the burst_len, count and warm-up counters.
- WARMUP, 4: LFSR advance cycles after seed load before output is valid. Range 0..2^CNT_W-1; 0 skips WARM.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a run; sampled only in IDLE.
- stop  in  1  abort the current run; ignored in IDLE.
- mode  in  1  0 = free-run until stop, 1 = burst of burst_len words; latched on accepted start.
- burst_len  in  CNT_W  burst length; latched on accepted start; unused when mode=0.
- out_rdy  in  1  consumer ready for a random word.
- out_val  out  1  random word on the datapath output is valid.
- lfsr_load  out  1  datapath loads seed register into LFSR this cycle.
- lfsr_en  out  1  datapath advances LFSR this cycle.
- active  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse when a burst completes normally.
- count  out  CNT_W  words remaining in the current burst.

Behaviour:
- Reset:
  - state=IDLE; count=0; warm counter=0; latched mode=0; done=0.
  - All outputs 0, including out_val, lfsr_load, lfsr_en and active.
  - Reset mid-run abandons the run immediately; no done pulse.
- States: IDLE, LOAD, WARM, RUN. Moore outputs, except lfsr_en in RUN.
- IDLE:
  - All outputs 0 except done.
  - start with mode=0, or with mode=1 and burst_len!=0: latch mode and burst_len into count, go to LOAD.
  - start with mode=1 and burst_len==0: stay in IDLE; done=1 next cycle.
  - stop is ignored. start and stop asserted together are treated as start.
- LOAD: lfsr_load=1, active=1, lfsr_en=0, out_val=0, for exactly one cycle. Next state is WARM if WARMUP>0, else RUN. Warm counter is cleared.
- WARM: lfsr_en=1, active=1, out_val=0. Warm counter increments each cycle; move to RUN on the cycle the counter reaches WARMUP-1, so WARM lasts exactly WARMUP cycles.
- RUN:
  - out_val=1, active=1.
  - lfsr_en = out_rdy: the handshake is out_val & out_rdy. The LFSR advances exactly once per accepted word.
  - Burst mode: count decrements on each handshake.
  - Handshake with count==1: count becomes 0, next state IDLE, done=1 in the following cycle.
  - Free-run mode: count holds its latched value and is not used; RUN continues until stop.
- stop in LOAD, WARM or RUN:
  - Next state is IDLE. No done pulse, unless the same cycle is the final burst handshake.
  - A handshake in the stop cycle still completes (lfsr_en=out_rdy) and count still decrements.
- done is registered: high in exactly one cycle, the first IDLE cycle after completion. A start accepted in that same cycle proceeds normally.
- start outside IDLE is ignored; it does not restart and does not reload count.
- Latency, start high at edge T:
  - LOAD in cycle T+1;
  - WARM in cycles T+2..T+1+WARMUP;
  - out_val first high in cycle T+2+WARMUP.
- No back-pressure limit: out_rdy may stay low indefinitely in RUN. The state holds, and lfsr_en stays 0.
- count wraps never: decrement occurs only while count>=1 in burst RUN.

Test Plan:
- Reset with rst=1 for 2 cycles mid-RUN, start low -> next cycle state IDLE, all outputs 0, count=0, no done pulse.
- Burst timing (WARMUP=4, CNT_W=8): start for 1 cycle with mode=1, burst_len=3, out_rdy held 1 ->
  - lfsr_load=1 in cycle 1;
  - lfsr_en=1 in cycles 2-5 with out_val=0;
  - out_val=1 and lfsr_en=1 in cycles 6-8, count 3->2->1->0;
  - done=1 in cycle 9, active=0 in cycle 9.
- Back-pressure: same burst with out_rdy toggling 1,0,0,1,0,1 from the first RUN cycle ->
  - lfsr_en mirrors out_rdy;
  - count decrements only on the 3 ready cycles;
  - done pulses the cycle after the 3rd handshake.
- Free-run and stop: mode=0, out_rdy=1, stop after 10 RUN cycles ->
  - 10 handshakes;
  - active falls the cycle after stop;
  - done never asserts.
- Zero-length burst and ignored start: mode=1, burst_len=0 with start -> no LOAD, done=1 next cycle, active stays 0. Also, start re-pulsed during WARM -> no LOAD repeat, timing unchanged.
- Corner overlap: stop coincident with final burst handshake -> count=0 and done=1 next cycle. With WARMUP=0, start -> out_val=1 two cycles after start.
